// File: rtl/chal_loader_if.sv
// Host and scan-chain signals of the challenge loader, bundled for port use.
interface chal_loader_if #(
  parameter int N  = 128,
  parameter int W  = 32,
  parameter int AW = $clog2(N / W)
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic          chal_si;
  logic          chal_clk_en;
  logic          chal_so;

  // Host side, which also models the downstream register's scan output.
  modport master (
    output wr_en, wr_addr, wr_data, start, rd_addr, chal_so,
    input  rd_data, busy, done, chal_si, chal_clk_en
  );

  // Loader side.
  modport slave (
    input  wr_en, wr_addr, wr_data, start, rd_addr, chal_so,
    output rd_data, busy, done, chal_si, chal_clk_en
  );
endinterface

// File: rtl/chal_loader.sv
// Challenge loader: holds a host-written N-bit challenge and streams it MSB
// first into the downstream scan chain, while capturing the chain's old
// contents into a readback register.
//
// state    | meaning
// ST_IDLE  | host may write ld; start launches a shift
// ST_SHIFT | N enabled cycles, one chain bit per cycle
// ST_DONE  | one-cycle done pulse, then back to idle
module chal_loader #(
  parameter int N  = 128,
  parameter int W  = 32,
  parameter int AW = $clog2(N / W)
) (
  input logic         clk,
  input logic         rstn,
  chal_loader_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t        state;
  logic [N-1:0]  ld;
  logic [N-1:0]  sb;
  logic [N-1:0]  rb;
  logic [N-1:0]  ld_merged;
  logic [CW-1:0] cnt;

  // Load register with the current cycle's host write folded in, so a write
  // issued alongside start is part of the challenge that gets shifted.
  always_comb begin
    ld_merged = ld;
    if (bus.wr_en) ld_merged[int'(bus.wr_addr) * W +: W] = bus.wr_data;
  end

  // Readback word select; only meaningful outside of a shift.
  assign bus.rd_data = rb[int'(bus.rd_addr) * W +: W];

  // Sequencer; all outputs registered so chal_clk_en comes straight off a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      ld              <= '0;
      sb              <= '0;
      rb              <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.chal_si     <= 1'b0;
      bus.chal_clk_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.wr_en) ld <= ld_merged;
          if (bus.start) begin
            sb              <= ld_merged;
            cnt             <= '0;
            state           <= ST_SHIFT;
            bus.busy        <= 1'b1;
            bus.chal_clk_en <= 1'b1;
            bus.chal_si     <= ld_merged[N-1];
          end
        end
        ST_SHIFT: begin
          rb  <= {rb[N-2:0], bus.chal_so};
          sb  <= {sb[N-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state           <= ST_DONE;
            bus.chal_clk_en <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.chal_si     <= 1'b0;
          end else begin
            // sb[N-2] becomes the MSB after this edge's shift.
            bus.chal_si <= sb[N-2];
          end
        end
        ST_DONE: begin
          bus.done <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state           <= ST_IDLE;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b0;
          bus.chal_si     <= 1'b0;
          bus.chal_clk_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chal_loader.sv
// Bench for chal_loader with a behavioural downstream scan register attached.
module tb_chal_loader;
  localparam int N  = 128;
  localparam int W  = 32;
  localparam int AW = 2;
  localparam int NW = N / W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  chal_loader_if #(.N(N), .W(W), .AW(AW)) bus ();

  chal_loader #(.N(N), .W(W), .AW(AW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  // Downstream challenge register: one shift per enabled clock, shares rstn.
  logic [N-1:0] c;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) c <= '0;
    else if (bus.chal_clk_en) c <= {c[N-2:0], bus.chal_si};
  end
  assign bus.chal_so = c[N-1];

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: the host's view of the load words and the chain contents.
  logic [W-1:0] ld_m [NW];
  logic [N-1:0] chain_m;

  function automatic logic [N-1:0] model_chal();
    logic [N-1:0] v;
    for (int i = 0; i < NW; i++) v[i*W +: W] = ld_m[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    ld_m[a] = d;
  endtask

  task automatic chk_rb(input string name, input logic [N-1:0] exp);
    logic [N-1:0] got;
    for (int i = 0; i < NW; i++) begin
      bus.rd_addr = AW'(i);
      #1;
      got[i*W +: W] = bus.rd_data;
    end
    chk(name, got, exp);
  endtask

  // Launch a shift and watch it: optional merged write with start, optional
  // start+write injection at a given shift index.
  task automatic shift(input string tag, input logic [N-1:0] exp, input bit merge,
                       input logic [AW-1:0] ma, input logic [W-1:0] md, input int inj_at);
    int nb;
    logic [N-1:0] st;
    bit en_ok;
    @(negedge clk);
    bus.start = 1'b1;
    if (merge) begin bus.wr_en = 1'b1; bus.wr_addr = ma; bus.wr_data = md; end
    @(negedge clk);
    bus.start = 1'b0; bus.wr_en = 1'b0;
    nb = 0; st = '0; en_ok = 1'b1;
    while (bus.busy && nb < N + 10) begin
      if (!bus.chal_clk_en || bus.done) en_ok = 1'b0;
      st = {st[N-2:0], bus.chal_si};
      if (nb == inj_at) begin
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = '1;
      end else if (nb == inj_at + 1) begin
        bus.start = 1'b0; bus.wr_en = 1'b0;
      end
      nb++;
      @(negedge clk);
    end
    bus.start = 1'b0; bus.wr_en = 1'b0;
    chk({tag, " busy_cycles"}, N'(nb), N'(N));
    chk({tag, " enable_during_busy"}, N'(en_ok), N'(1));
    chk({tag, " si_stream"}, st, exp);
    chk({tag, " done_pulse"}, N'({bus.done, bus.busy, bus.chal_clk_en, bus.chal_si}), N'(4'b1000));
    chk({tag, " downstream_c"}, c, exp);
    @(negedge clk);
    chk({tag, " done_clear"}, N'({bus.done, bus.busy, bus.chal_clk_en}), N'(0));
  endtask

  typedef struct {
    logic [NW-1:0][W-1:0] w;
    logic [N-1:0]         exp_c;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [N-1:0] exp;
    logic [AW-1:0] a;
    logic [W-1:0] d;
    bit merge;

    tbl[0].w = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
    tbl[0].exp_c = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    tbl[1].w = {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1].exp_c = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    tbl[2].w = {32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    tbl[2].exp_c = 128'h12345678_12345678_12345678_12345678;
    tbl[3].w = {32'hFFFFFFFF, 32'h00000000, 32'hAAAAAAAA, 32'h55555555};
    tbl[3].exp_c = 128'hFFFFFFFF_00000000_AAAAAAAA_55555555;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.rd_addr = '0;
    for (int i = 0; i < NW; i++) ld_m[i] = '0;
    chain_m = '0;

    // Reset state.
    #2;
    chk("reset_outputs", N'({bus.busy, bus.done, bus.chal_si, bus.chal_clk_en}), N'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_outputs", N'({bus.busy, bus.done, bus.chal_si, bus.chal_clk_en}), N'(0));
    chk_rb("reset_rb", '0);

    // Empty challenge.
    shift("zero_ld", '0, 1'b0, '0, '0, -10);

    // Fixed vectors; rb must hold whatever the chain held before.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NW; i++) wr(AW'(i), tbl[v].w[i]);
      chk($sformatf("tbl%0d_model", v), model_chal(), tbl[v].exp_c);
      shift($sformatf("tbl%0d", v), tbl[v].exp_c, 1'b0, '0, '0, -10);
      chk_rb($sformatf("tbl%0d_rb", v), chain_m);
      chain_m = tbl[v].exp_c;
    end

    // Write and start in the same idle cycle, over a cleared load register.
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < NW; i++) ld_m[i] = '0;
    chain_m = '0;
    ld_m[3] = 32'h80000000;
    shift("merge", 128'h1 << 127, 1'b1, 2'd3, 32'h80000000, -10);
    chain_m = model_chal();

    // Start and write while shifting are ignored.
    shift("inject", model_chal(), 1'b0, '0, '0, 50);
    chk_rb("inject_rb", chain_m);
    shift("after_inject", model_chal(), 1'b0, '0, '0, -10);

    // Reset in the middle of a shift.
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (60) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midreset_outputs", N'({bus.busy, bus.done, bus.chal_clk_en}), N'(0));
    chk_rb("midreset_rb", '0);
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < NW; i++) ld_m[i] = '0;
    chain_m = '0;
    shift("post_reset", '0, 1'b0, '0, '0, -10);
    chk_rb("post_reset_rb", '0);

    // Randomized loads against the model.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        wr(AW'($urandom_range(0, NW - 1)), $urandom);
      merge = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, NW - 1));
      d = $urandom;
      if (merge) ld_m[a] = d;
      exp = model_chal();
      shift($sformatf("rand%0d", it), exp, merge, a, d, -10);
      chk_rb($sformatf("rand%0d_rb", it), chain_m);
      chain_m = exp;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
